ads127l1x_config_sequencer: RTL and testbench

Power-up and run-control sequencer for the ADS127L18/ADS127L14. On `go`, it pulses the ADC RESET pin and waits for the power-on settle time. It then writes a table of register values over SPI (mode 1) and, optionally, reads each one back to verify it. Finally it asserts START so the TDM deserializer begins receiving frames. It sits beside the deserializer in the ADC capture top level, and all of its logic runs on the system clock.

---
 rtl/ads127l1x_cfg_pkg.sv | 52 +++++
 rtl/ads127l1x_spi_frame.sv | 119 +++++++++++
 rtl/ads127l1x_config_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_ads127l1x_config_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ads127l1x_cfg_pkg.sv
// Shared constants, state encodings and frame builders for the ADS127L1x config sequencer.
package ads127l1x_cfg_pkg;

  localparam logic [2:0]  OP_WR     = 3'b010;
  localparam logic [2:0]  OP_RD     = 3'b001;
  localparam logic [15:0] NOP_FRAME = 16'h0000;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_RST_LOW  = 4'd1;
  localparam logic [3:0] ST_RST_WAIT = 4'd2;
  localparam logic [3:0] ST_FETCH    = 4'd3;
  localparam logic [3:0] ST_WR       = 4'd4;
  localparam logic [3:0] ST_RD_CMD   = 4'd5;
  localparam logic [3:0] ST_RD_DATA  = 4'd6;
  localparam logic [3:0] ST_VERIFY   = 4'd7;
  localparam logic [3:0] ST_NEXT     = 4'd8;
  localparam logic [3:0] ST_START    = 4'd9;
  localparam logic [3:0] ST_RUN      = 4'd10;
  localparam logic [3:0] ST_ERROR    = 4'd11;

  typedef enum logic [3:0] {
    StIdle    = ST_IDLE,
    StRstLow  = ST_RST_LOW,
    StRstWait = ST_RST_WAIT,
    StFetch   = ST_FETCH,
    StWr      = ST_WR,
    StRdCmd   = ST_RD_CMD,
    StRdData  = ST_RD_DATA,
    StVerify  = ST_VERIFY,
    StNext    = ST_NEXT,
    StStart   = ST_START,
    StRun     = ST_RUN,
    StError   = ST_ERROR
  } seq_state_e;

  typedef enum logic [1:0] {
    FrIdle,
    FrLead,
    FrShift,
    FrTrail
  } frame_state_e;

  // entry is {addr[4:0], data[7:0]}; the upper address bits are not encodable in a frame
  function automatic logic [15:0] wr_frame(input logic [12:0] entry);
    return {OP_WR, entry[12:8], entry[7:0]};
  endfunction

  function automatic logic [15:0] rd_frame(input logic [12:0] entry);
    return {OP_RD, entry[12:8], 8'h00};
  endfunction

endpackage

// File: rtl/ads127l1x_spi_frame.sv
// One 16-bit SPI mode-1 transfer: MOSI launched on SCLK rise, MISO sampled on SCLK fall.
module ads127l1x_spi_frame
  import ads127l1x_cfg_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] tx_word,
  input  logic        spi_miso,
  output logic        done,
  output logic [15:0] rx_word,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi
);

  localparam int unsigned DIV_W = $clog2(SCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  frame_state_e     state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      tx_q, tx_d;
  logic [15:0]      rx_q, rx_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             done_q, done_d;
  logic             div_tick;

  assign div_tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_tick ? '0 : div_q + DIV_W'(1);
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    unique case (state_q)
      FrIdle: begin
        div_d = '0;
        if (start) begin
          state_d = FrLead;
          cs_n_d  = 1'b0;
          tx_d    = tx_word;
          bit_d   = '0;
        end
      end
      FrLead: begin
        if (div_tick) begin
          sclk_d  = 1'b1;
          mosi_d  = tx_q[15];
          tx_d    = {tx_q[14:0], 1'b0};
          state_d = FrShift;
        end
      end
      FrShift: begin
        if (div_tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            rx_d   = {rx_q[14:0], spi_miso};
            if (bit_q == 4'd15) state_d = FrTrail;
            else                bit_d   = bit_q + 4'd1;
          end else begin
            sclk_d = 1'b1;
            mosi_d = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
          end
        end
      end
      FrTrail: begin
        if (div_tick) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FrIdle;
        end
      end
      default: state_d = FrIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FrIdle;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign done     = done_q;
  assign rx_word  = rx_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: rtl/ads127l1x_config_sequencer.sv
// ADS127L1x power-up / register-load / START sequencer.
// Optional register readback verification is enabled by ADS127L1X_CFG_READBACK_EN.
module ads127l1x_config_sequencer
  import ads127l1x_cfg_pkg::*;
#(
  parameter int unsigned SCLK_DIV        = 4,
  parameter int unsigned NUM_REGS        = 16,
  parameter int unsigned RST_LOW_CYCLES  = 64,
  parameter int unsigned RST_WAIT_CYCLES = 20000,
  parameter int unsigned CS_GAP_CYCLES   = 8
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST,
  input  logic        go,
  input  logic        halt,
  output logic [4:0]  cfg_index,
  input  logic [15:0] cfg_word,
  output logic        adc_reset_n,
  output logic        adc_start,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        busy,
  output logic        running,
  output logic        error,
  output logic [4:0]  err_index
);

  localparam int unsigned CNT_MAX =
      (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam int unsigned GAP_W = $clog2(CS_GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(CS_GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP_CYCLES - 1);
  localparam logic [4:0]       LAST_IDX = 5'(NUM_REGS - 1);

  seq_state_e       state_q, state_d, frame_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             step_q, step_d;
  logic             halt_pend_q, halt_pend_d;
  logic [4:0]       idx_q, idx_d;
  logic [12:0]      cfg_q, cfg_d;
  logic             rst_n_q, rst_n_d;
  logic             start_q, start_d;
  logic             frame_start, frame_done, gap_ok;
  logic [15:0]      frame_tx, frame_rx;
  logic             unused_bits;

`ifdef ADS127L1X_CFG_READBACK_EN
  logic [7:0] rd_q, rd_d;
  logic [4:0] err_idx_q, err_idx_d;
  assign unused_bits = ^{frame_rx[15:8], cfg_word[15:13]};
`else
  assign unused_bits = ^{frame_rx, cfg_word[15:13]};
`endif

  ads127l1x_spi_frame #(
    .SCLK_DIV(SCLK_DIV)
  ) u_spi_frame (
    .clk     (SYS_CLK),
    .rst     (SYS_RST),
    .start   (frame_start),
    .tx_word (frame_tx),
    .spi_miso(spi_miso),
    .done    (frame_done),
    .rx_word (frame_rx),
    .spi_cs_n(spi_cs_n),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi)
  );

  // CS-high time since the last frame; gates every frame launch and the NEXT state
  assign gap_d  = !spi_cs_n ? '0 : ((gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1));
  assign gap_ok = (gap_q >= GAP_LAST);

  always_comb begin
    frame_tx   = NOP_FRAME;
    frame_next = StNext;
    unique case (state_q)
      StWr: begin
        frame_tx = wr_frame(cfg_q);
`ifdef ADS127L1X_CFG_READBACK_EN
        frame_next = StRdCmd;
`endif
      end
`ifdef ADS127L1X_CFG_READBACK_EN
      StRdCmd: begin
        frame_tx   = rd_frame(cfg_q);
        frame_next = StRdData;
      end
      StRdData: frame_next = StVerify;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    step_d      = step_q;
    halt_pend_d = halt_pend_q;
    idx_d       = idx_q;
    cfg_d       = cfg_q;
    frame_start = 1'b0;
`ifdef ADS127L1X_CFG_READBACK_EN
    rd_d      = rd_q;
    err_idx_d = err_idx_q;
`endif
    unique case (state_q)
      StIdle: if (go && !halt) state_d = StRstLow;
      StRstLow: begin
        if (halt) state_d = StIdle;
        else if (cnt_q == CNT_W'(RST_LOW_CYCLES - 1)) state_d = StRstWait;
      end
      StRstWait: begin
        if (halt) state_d = StIdle;
        else if (cnt_q == CNT_W'(RST_WAIT_CYCLES - 1)) begin
          idx_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // first cycle lets cfg_word settle after the index change, second latches it
        if (halt) state_d = StIdle;
        else if (!step_q) step_d = 1'b1;
        else begin
          cfg_d   = cfg_word[12:0];
          state_d = StWr;
        end
      end
`ifdef ADS127L1X_CFG_READBACK_EN
      StWr, StRdCmd, StRdData: begin
`else
      StWr: begin
`endif
        if (!step_q) begin
          if (halt) state_d = StIdle;
          else if (gap_ok) begin
            frame_start = 1'b1;
            step_d      = 1'b1;
          end
        end else begin
          if (halt) halt_pend_d = 1'b1;
          if (frame_done) begin
            state_d = (halt || halt_pend_q) ? StIdle : frame_next;
`ifdef ADS127L1X_CFG_READBACK_EN
            if (state_q == StRdData) rd_d = frame_rx[7:0];
`endif
          end
        end
      end
`ifdef ADS127L1X_CFG_READBACK_EN
      StVerify: begin
        if (halt) state_d = StIdle;
        else if (rd_q != cfg_q[7:0]) begin
          err_idx_d = idx_q;
          state_d   = StError;
        end else state_d = StNext;
      end
`endif
      StNext: begin
        if (halt) state_d = StIdle;
        else if (gap_ok) begin
          if (idx_q == LAST_IDX) state_d = StStart;
          else begin
            idx_d   = idx_q + 5'd1;
            state_d = StFetch;
          end
        end
      end
      StStart: state_d = halt ? StIdle : StRun;
      StRun, StError: begin
        if (halt) state_d = StIdle;
        else if (go) state_d = StRstLow;
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) begin
      cnt_d       = '0;
      step_d      = 1'b0;
      halt_pend_d = 1'b0;
    end
    rst_n_d = (state_d != StRstLow);
    start_d = (state_d == StStart) || (state_d == StRun);
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      gap_q       <= GAP_MAX;
      step_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      idx_q       <= '0;
      cfg_q       <= '0;
      rst_n_q     <= 1'b1;
      start_q     <= 1'b0;
`ifdef ADS127L1X_CFG_READBACK_EN
      rd_q        <= '0;
      err_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      step_q      <= step_d;
      halt_pend_q <= halt_pend_d;
      idx_q       <= idx_d;
      cfg_q       <= cfg_d;
      rst_n_q     <= rst_n_d;
      start_q     <= start_d;
`ifdef ADS127L1X_CFG_READBACK_EN
      rd_q        <= rd_d;
      err_idx_q   <= err_idx_d;
`endif
    end
  end

  assign cfg_index   = idx_q;
  assign adc_reset_n = rst_n_q;
  assign adc_start   = start_q;
  assign busy        = !(state_q inside {StIdle, StRun, StError});
  assign running     = (state_q == StRun);
`ifdef ADS127L1X_CFG_READBACK_EN
  assign error       = (state_q == StError);
  assign err_index   = err_idx_q;
`else
  assign error       = 1'b0;
  assign err_index   = 5'd0;
`endif

endmodule

// File: tb/tb_ads127l1x_config_sequencer.sv
// Directed bench for ads127l1x_config_sequencer with an SPI slave model and frame timing checker.
module tb_ads127l1x_config_sequencer;

  localparam int unsigned SDIV = 4;

  logic        SYS_CLK = 1'b0;
  logic        SYS_RST = 1'b1;
  logic        go = 1'b0;
  logic        halt = 1'b0;
  logic        spi_miso = 1'b0;
  logic [15:0] cfg_word;
  logic [4:0]  cfg_index, err_index;
  logic        adc_reset_n, adc_start, spi_cs_n, spi_sclk, spi_mosi;
  logic        busy, running, error;

  int checks = 0;
  int errors = 0;

  // slave / monitor state
  logic        cs_p = 1'b1, sclk_p = 1'b0, mosi_p = 1'b0, have_frame = 1'b0;
  int          hi_cnt = 100, lvl_cnt = 0, rises = 0;
  logic [15:0] sh = '0, resp = '0, pending = '0;
  logic [7:0]  regs [32];
  int          corrupt_addr = -1;
  logic [15:0] frames [$];
  int          rise_q [$];

`ifdef ADS127L1X_CFG_READBACK_EN
  logic [15:0] exp_fr [6] = '{16'h4125, 16'h2100, 16'h0000, 16'h4280, 16'h2200, 16'h0000};
`else
  logic [15:0] exp_fr [2] = '{16'h4125, 16'h4280};
`endif

  ads127l1x_config_sequencer #(
    .SCLK_DIV       (SDIV),
    .NUM_REGS       (2),
    .RST_LOW_CYCLES (64),
    .RST_WAIT_CYCLES(100),
    .CS_GAP_CYCLES  (8)
  ) dut (
    .SYS_CLK    (SYS_CLK),
    .SYS_RST    (SYS_RST),
    .go         (go),
    .halt       (halt),
    .cfg_index  (cfg_index),
    .cfg_word   (cfg_word),
    .adc_reset_n(adc_reset_n),
    .adc_start  (adc_start),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .busy       (busy),
    .running    (running),
    .error      (error),
    .err_index  (err_index)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  always_comb begin
    case (cfg_index)
      5'd0:    cfg_word = 16'h0125;
      5'd1:    cfg_word = 16'h0280;
      default: cfg_word = 16'h0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode-1 slave: drives MISO after each SCLK rise, captures MOSI on each fall
  always @(negedge SYS_CLK) begin
    if (SYS_RST) begin
      cs_p = 1'b1; sclk_p = 1'b0; mosi_p = 1'b0; have_frame = 1'b0;
      hi_cnt = 100; lvl_cnt = 0; rises = 0; spi_miso = 1'b0;
    end else begin
      if (!cs_p && spi_cs_n) begin
        frames.push_back(sh);
        rise_q.push_back(rises);
        if (sh[15:13] == 3'b010) regs[sh[12:8]] = sh[7:0];
        else if (sh[15:13] == 3'b001)
          pending = {8'h00, regs[sh[12:8]] ^ ((int'(sh[12:8]) == corrupt_addr) ? 8'h01 : 8'h00)};
        have_frame = 1'b1;
        hi_cnt = 0;
      end
      if (cs_p && !spi_cs_n) begin
        if (have_frame) check("cs_gap_ge_8", hi_cnt >= 8, 1);
        rises = 0; sh = '0; resp = pending; pending = '0;
      end
      if (spi_cs_n) hi_cnt++;
      if (spi_sclk != sclk_p) begin
        if (spi_sclk) begin
          if (rises > 0) check("sclk_low_len", lvl_cnt, SDIV);
          if (rises < 16) spi_miso = resp[15 - rises];
          rises++;
        end else begin
          check("sclk_high_len", lvl_cnt, SDIV);
          check("mosi_stable_fall", spi_mosi, mosi_p);
          sh = {sh[14:0], spi_mosi};
        end
        lvl_cnt = 1;
      end else lvl_cnt++;
      cs_p = spi_cs_n; sclk_p = spi_sclk; mosi_p = spi_mosi;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge SYS_CLK);
    SYS_RST = 1'b0;
    @(negedge SYS_CLK);
    check("rst_adc_reset_n", adc_reset_n, 1);
    check("rst_adc_start", adc_start, 0);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_cfg_index", cfg_index, 0);
    check("rst_busy", busy, 0);
    check("rst_running", running, 0);
    check("rst_error", error, 0);
    check("rst_err_index", err_index, 0);

    // full sequence from IDLE
    frames.delete(); rise_q.delete();
    go = 1'b1; @(negedge SYS_CLK); go = 1'b0;
    check("busy_after_go", busy, 1);
    n = 0;
    while (adc_reset_n == 1'b0 && n < 1000) begin n++; @(negedge SYS_CLK); end
    check("reset_low_width", n, 64);
    for (n = 0; n < 5000 && !running; n++) @(negedge SYS_CLK);
    check("run_reached", running, 1);
    check("adc_start_in_run", adc_start, 1);
    check("busy_in_run", busy, 0);
    check("no_error", error, 0);
    check("last_index", cfg_index, 1);
    check("frame_count", frames.size(), $size(exp_fr));
    for (int i = 0; i < $size(exp_fr); i++) begin
      if (i < frames.size()) begin
        check("frame_word", frames[i], exp_fr[i]);
        check("frame_rises", rise_q[i], 16);
      end
    end

    // go from RUN restarts, then halt mid write frame
    frames.delete(); rise_q.delete();
    go = 1'b1; @(negedge SYS_CLK); go = 1'b0;
    check("start_drop_on_go", adc_start, 0);
    check("reset_low_on_rego", adc_reset_n, 0);
    for (n = 0; n < 2000 && spi_cs_n; n++) @(negedge SYS_CLK);
    check("cs_fall_seen", spi_cs_n, 0);
    repeat (20) @(negedge SYS_CLK);
    halt = 1'b1; @(negedge SYS_CLK); halt = 1'b0;
    check("halt_deferred_busy", busy, 1);
    check("halt_deferred_cs", spi_cs_n, 0);
    for (n = 0; n < 400 && !spi_cs_n; n++) @(negedge SYS_CLK);
    check("cs_rise_after_halt", spi_cs_n, 1);
    repeat (2) @(negedge SYS_CLK);
    check("halt_idle_busy", busy, 0);
    check("halt_idle_running", running, 0);
    check("halt_idle_start", adc_start, 0);
    check("halt_frame_count", frames.size(), 1);
    if (frames.size() > 0) begin
      check("halt_frame_word", frames[0], 16'h4125);
      check("halt_frame_rises", rise_q[0], 16);
    end
    repeat (100) @(negedge SYS_CLK);
    check("no_frame_after_halt", frames.size(), 1);

    // go ignored while busy, then async reset in RST_WAIT
    go = 1'b1; @(negedge SYS_CLK); go = 1'b0;
    for (n = 0; n < 200 && !adc_reset_n; n++) @(negedge SYS_CLK);
    check("reset_released", adc_reset_n, 1);
    repeat (5) @(negedge SYS_CLK);
    go = 1'b1; @(negedge SYS_CLK); go = 1'b0;
    @(negedge SYS_CLK);
    check("go_ignored_busy", adc_reset_n, 1);
    check("still_busy", busy, 1);
    #2 SYS_RST = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_reset_n", adc_reset_n, 1);
    check("async_rst_cs", spi_cs_n, 1);
    check("async_rst_index", cfg_index, 0);
    @(negedge SYS_CLK);
    SYS_RST = 1'b0;
    @(negedge SYS_CLK);
    frames.delete(); rise_q.delete();
    go = 1'b1; @(negedge SYS_CLK); go = 1'b0;
    n = 0;
    while (adc_reset_n == 1'b0 && n < 1000) begin n++; @(negedge SYS_CLK); end
    check("reset_low_after_rst", n, 64);
    for (n = 0; n < 5000 && !running; n++) @(negedge SYS_CLK);
    check("run_after_rst", running, 1);
    check("frames_after_rst", frames.size(), $size(exp_fr));

    // halt in RUN
    halt = 1'b1; @(negedge SYS_CLK); halt = 1'b0;
    check("run_halt_running", running, 0);
    check("run_halt_start", adc_start, 0);
    check("run_halt_busy", busy, 0);

`ifdef ADS127L1X_CFG_READBACK_EN
    // readback mismatch on entry 1
    corrupt_addr = 2;
    frames.delete(); rise_q.delete();
    go = 1'b1; @(negedge SYS_CLK); go = 1'b0;
    for (n = 0; n < 5000 && !error; n++) @(negedge SYS_CLK);
    check("mismatch_error", error, 1);
    check("mismatch_err_index", err_index, 1);
    check("mismatch_start", adc_start, 0);
    check("mismatch_running", running, 0);
    check("mismatch_busy", busy, 0);
    check("mismatch_frames", frames.size(), 6);
    repeat (200) @(negedge SYS_CLK);
    check("no_frames_in_error", frames.size(), 6);
    halt = 1'b1; @(negedge SYS_CLK); halt = 1'b0;
    check("error_cleared_by_halt", error, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
